seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode 7-segment display bank.
- One shared BCD-to-segment decode path is sequenced across DIGITS anodes.
- A shadow register holds the displayed value so the display is glitch-free.
- Optional leading-zero blanking, a per-digit enable mask, and an anti-ghosting blank gap between digits.
- Sits between the lab counter/datapath and the board segment/anode pins.

Parameters:
- DIGITS, 8, number of multiplexed digits (2..8).
- SLOT_CYC, 100000, clock cycles per digit slot, blank gap included.
- BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; 1 <= BLANK_CYC < SLOT_CYC.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- value_i  input  4*DIGITS  packed BCD nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is rightmost.
- load_i  input  1  when high at a clock edge, shadow register <= value_i.
- digit_en_i  input  DIGITS  per-digit enable; 0 forces that anode off.
- lzb_i  input  1  leading-zero blanking enable.
- digit_o  output  DIGITS  anode select, active-low, one-hot-low or all ones.
- hex_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_o  output  1  one-cycle pulse at each wrap from digit DIGITS-1 to digit 0.

Behaviour:
- Reset (async, immediate, no clock needed):
  - digit_o = all ones, hex_o = 7'b111_1111, frame_o = 0.
  - shadow = 0, idx = 0, slot counter = 0, state = BLANK.
- FSM states:
  - BLANK: counter counts 0..BLANK_CYC-1. Then go to SHOW.
  - SHOW: counter continues to SLOT_CYC-1. Then go to BLANK with idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - Every slot is exactly SLOT_CYC cycles. Frame period is DIGITS*SLOT_CYC cycles, independent of masks and blanking.
- Outputs are registered and reflect the current state:
  - In BLANK: digit_o = all ones, hex_o = 7F.
  - In SHOW with digit idx visible: digit_o[idx] = 0 (others 1), hex_o = decode(shadow nibble idx).
  - In SHOW with digit idx not visible: digit_o = all ones, hex_o = 7F. The slot time is still consumed.
- First anode assertion after reset release occurs BLANK_CYC cycles after the first clock edge.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10..15 = 1111111 (blank, anode still driven).
- Visibility: digit k is visible iff digit_en_i[k] = 1 and it is not leading-blanked.
  - With lzb_i = 1, digit k > 0 is leading-blanked iff shadow nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never leading-blanked.
  - Visibility is evaluated combinationally from the current shadow, digit_en_i and lzb_i, then registered.
- Load latency:
  - load_i sampled at edge N updates shadow at N.
  - hex_o/digit_o reflect the new value from edge N+1, if in SHOW.
  - A load mid-SHOW changes the currently lit digit without restarting the slot.
- frame_o: high for exactly the one cycle following the edge where idx wraps DIGITS-1 -> 0, i.e. the first BLANK cycle of digit 0.
- Input changes never alter slot timing. digit_en_i and lzb_i changes take effect one edge later, like load.
- Reset asserted mid-operation aborts the slot and restarts from digit 0 in BLANK. The shadow is cleared.

Test Plan (bench with DIGITS=4, SLOT_CYC=8, BLANK_CYC=2):
1. Assert rst_i without clock -> digit_o=1111, hex_o=1111111, frame_o=0 immediately. Release -> digit_o=1110 first at edge 2, held 6 cycles, then 1111 for 2 cycles, then 1101.
2. load_i with value_i=16'h1234 -> across one frame, slots show digit0 0011001, digit1 0110000, digit2 0100100, digit3 1111001. frame_o pulses once every 32 cycles.
3. value_i=16'h00A7, lzb_i=0 -> digit0 1111000, digit1 anode low with hex_o 1111111, digits 2/3 anode low with 1000000.
4. lzb_i=1: value 16'h0050 -> digits 3,2 anodes never low, digit1 0010010, digit0 1000000. Value 16'h0000 -> only digit0 lit (1000000). Frame period still 32.
5. digit_en_i=1011 with 16'h8888 -> digit2 slot has digit_o=1111 for all 8 cycles, others show 0000000. Load 16'h1111 while digit0 lit -> hex_o becomes 1111001 one edge after the load edge, slot length unchanged.
6. Assert rst_i during SHOW of digit 2 -> outputs go off asynchronously. After release the sequence restarts at digit 0 BLANK with shadow = 0 (digit0 shows 1000000).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a common-anode 7-segment bank: one shared BCD decoder is
// sequenced across DIGITS anodes, with a blank gap at the start of every slot.
module seg7_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SLOT_CYC  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [4*DIGITS-1:0] value_i,
    input  logic                load_i,
    input  logic [DIGITS-1:0]   digit_en_i,
    input  logic                lzb_i,
    output logic [DIGITS-1:0]   digit_o,
    output logic [6:0]          hex_o,
    output logic                frame_o
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(SLOT_CYC);

    localparam logic [IW-1:0]     IDX_LAST       = IW'(DIGITS - 1);
    localparam logic [CW-1:0]     CNT_BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]     CNT_SLOT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [DIGITS-1:0] DIG_ONE        = DIGITS'(1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0]        digit_q, digit_d;
    logic [6:0]               hex_q, hex_d;
    logic                     frame_q, frame_d;
    logic [DIGITS-1:0]        visible;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the segments.
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Slot sequencing: timing never depends on data, masks or blanking.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        frame_d = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_BLANK_LAST) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_SLOT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    frame_d = (idx_q == IDX_LAST);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Digit k is leading-blanked when it and every digit above it are zero.
    always_comb begin : vis_calc
        logic all_zero;
        all_zero = 1'b1;
        visible  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero   = all_zero && (shadow_q[k] == 4'd0);
            visible[k] = digit_en_i[k] && !(lzb_i && (k != 0) && all_zero);
        end
    end

    always_comb begin
        shadow_d = load_i ? value_i : shadow_q;
        digit_d  = '1;
        hex_d    = 7'b1111111;
        if (state_d == ST_SHOW && visible[idx_d]) begin
            digit_d = ~(DIG_ONE << idx_d);
            hex_d   = decode(shadow_q[idx_d]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            // NOTE: the shadow is a handful of flops, not a RAM, so it is cleared by reset like the rest of the state.
            shadow_q <= '0;
            digit_q  <= '1;
            hex_q    <= 7'b1111111;
            frame_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            digit_q  <= digit_d;
            hex_q    <= hex_d;
            frame_q  <= frame_d;
        end
    end

    assign digit_o = digit_q;
    assign hex_o   = hex_q;
    assign frame_o = frame_q;

endmodule
